// File: rtl/ysyx22041405_id_ex_stage.sv
// ID->EX pipeline register with valid/ready handshake and flush.
// Define YSYX22041405_IDEX_SKID_EN for a main+skid buffer with a registered id_ready.
module ysyx22041405_id_ex_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [WIDTH-1:0]       id_imm,
  input  logic [WIDTH-1:0]       id_rf_rdata1,
  input  logic [WIDTH-1:0]       id_rf_rdata2,
  input  logic [WIDTH-1:0]       id_pc,
  input  logic [WIDTH-1:0]       id_inst,
  input  logic [4:0]             id_rf_waddr,
  input  logic [13:0]            id_alu_Ctrl,
  input  logic [5:0]             id_flags,
  input  logic                   flush,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [5*WIDTH+24:0]    ID_EX_message
);

  localparam int unsigned MSG_W = 5 * WIDTH + 25;

  logic [MSG_W-1:0] in_msg;
  logic             accept;
  logic             complete;
  logic             main_vld_q, main_vld_d;
  logic [MSG_W-1:0] main_q, main_d;

  // ctrl (alu one-hot, flags) on top, data fields below
  assign in_msg   = {id_alu_Ctrl, id_flags, id_imm, id_rf_rdata1, id_rf_rdata2,
                     id_rf_waddr, id_pc, id_inst};
  assign accept   = id_valid & id_ready;
  assign complete = main_vld_q & ex_ready;

  // Held payload is zeroed whenever it is invalid, so the output needs no gating
  assign ex_valid      = main_vld_q;
  assign ID_EX_message = main_q;

`ifdef YSYX22041405_IDEX_SKID_EN
  logic             skid_vld_q, skid_vld_d;
  logic [MSG_W-1:0] skid_q, skid_d;

  assign id_ready = ~skid_vld_q & ~rst;

  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (flush) begin
      main_vld_d = 1'b0;
      main_d     = '0;
      skid_vld_d = 1'b0;
      skid_d     = '0;
    end else if (complete) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_d     = skid_q;
        skid_vld_d = 1'b0;
        skid_d     = '0;
      end else if (accept) begin
        main_vld_d = 1'b1;
        main_d     = in_msg;
      end else begin
        main_vld_d = 1'b0;
        main_d     = '0;
      end
    end else if (accept) begin
      // Main still occupied by a stalled message: park the new one in skid
      if (!main_vld_q) begin
        main_vld_d = 1'b1;
        main_d     = in_msg;
      end else begin
        skid_vld_d = 1'b1;
        skid_d     = in_msg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      main_q     <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_q     <= main_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end
`else
  assign id_ready = ~rst & (~main_vld_q | ex_ready);

  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    if (flush) begin
      main_vld_d = 1'b0;
      main_d     = '0;
    end else if (accept) begin
      main_vld_d = 1'b1;
      main_d     = in_msg;
    end else if (complete) begin
      main_vld_d = 1'b0;
      main_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      main_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_q     <= main_d;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx22041405_id_ex_stage.sv
// Bench for ysyx22041405_id_ex_stage: directed table, back-to-back stream and random
// traffic checked against a queue model of the stage.
module tb_ysyx22041405_id_ex_stage;

  localparam int unsigned W  = 32;
  localparam int unsigned MW = 5 * W + 25;
`ifdef YSYX22041405_IDEX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic          id_ready;
  logic [W-1:0]  id_imm = '0, id_rf_rdata1 = '0, id_rf_rdata2 = '0, id_pc = '0, id_inst = '0;
  logic [4:0]    id_rf_waddr = '0;
  logic [13:0]   id_alu_Ctrl = '0;
  logic [5:0]    id_flags = '0;
  logic          flush = 1'b0;
  logic          ex_valid;
  logic          ex_ready = 1'b0;
  logic [MW-1:0] ID_EX_message;

  int nvec = 0;
  int nerr = 0;
  logic [MW-1:0] mq[$];

  always #5 clk = ~clk;

  ysyx22041405_id_ex_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_imm(id_imm), .id_rf_rdata1(id_rf_rdata1), .id_rf_rdata2(id_rf_rdata2),
    .id_pc(id_pc), .id_inst(id_inst), .id_rf_waddr(id_rf_waddr),
    .id_alu_Ctrl(id_alu_Ctrl), .id_flags(id_flags), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ID_EX_message(ID_EX_message)
  );

  function automatic logic [31:0] P(int k);
    return 32'h8000_0000 + 32'(4 * k);
  endfunction
  function automatic logic [31:0] inst_of(logic [31:0] pc);
    return (pc == 32'h8000_0000) ? 32'h0010_0073 : (pc ^ 32'h5a5a_0013);
  endfunction
  function automatic logic [5:0] flags_of(logic [31:0] pc);
    return (pc == 32'h8000_0000) ? 6'b000101 : (pc[7:2] | 6'b000001);
  endfunction
  function automatic logic [13:0] alu_of(logic [31:0] pc);
    logic [13:0] one = 14'd1;
    return one << (int'(pc[5:2]) % 14);
  endfunction
  function automatic logic [MW-1:0] pack(logic [31:0] pc);
    return {alu_of(pc), flags_of(pc), ~pc, pc + 32'd1, pc * 32'd3, pc[6:2], pc, inst_of(pc)};
  endfunction

  function automatic bit model_ready();
    if (rst) return 1'b0;
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || ex_ready;
  endfunction

  function automatic void chk(string nm, logic [MW+1:0] got, logic [MW+1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  task automatic drive(bit r, bit f, bit v, bit e, logic [31:0] pc);
    @(negedge clk);
    rst = r; flush = f; id_valid = v; ex_ready = e;
    id_pc = pc; id_inst = inst_of(pc); id_flags = flags_of(pc); id_alu_Ctrl = alu_of(pc);
    id_imm = ~pc; id_rf_rdata1 = pc + 32'd1; id_rf_rdata2 = pc * 32'd3; id_rf_waddr = pc[6:2];
    #1;
  endtask

  task automatic advance();
    bit acc, cmp;
    logic [MW-1:0] m;
    acc = id_valid && model_ready();
    cmp = (mq.size() > 0) && ex_ready;
    m = pack(id_pc);
    @(posedge clk);
    if (rst || flush) mq.delete();
    else begin
      if (cmp) void'(mq.pop_front());
      if (acc) mq.push_back(m);
    end
  endtask

  task automatic chk_model(string nm);
    bit ev;
    logic [MW-1:0] em;
    ev = mq.size() > 0;
    em = ev ? mq[0] : '0;
    chk(nm, {id_ready, ex_valid, ID_EX_message}, {model_ready(), ev, em});
  endtask

  typedef struct {
    bit r, f, v, e;
    logic [31:0] pc;
    bit er1, ev1; logic [31:0] ep1;
    bit er2, ev2; logic [31:0] ep2;
  } vec_t;

  initial begin
    vec_t tbl[19];
    int k, ndel, bub, cyc;
    tbl[0]  = '{1,0,1,0, P(20), 0,0,0,     0,0,0};
    tbl[1]  = '{0,0,1,0, P(0),  1,0,0,     1,0,0};
    tbl[2]  = '{0,0,0,0, P(0),  0,1,P(0),  1,1,P(0)};
    tbl[3]  = '{0,0,1,0, P(1),  0,1,P(0),  1,1,P(0)};
    tbl[4]  = '{0,0,1,0, P(2),  0,1,P(0),  0,1,P(0)};
    tbl[5]  = '{0,0,1,0, P(2),  0,1,P(0),  0,1,P(0)};
    tbl[6]  = '{0,0,1,0, P(2),  0,1,P(0),  0,1,P(0)};
    tbl[7]  = '{0,0,1,1, P(2),  1,1,P(0),  0,1,P(0)};
    tbl[8]  = '{0,0,0,1, P(2),  1,1,P(2),  1,1,P(1)};
    tbl[9]  = '{0,0,1,0, P(3),  1,0,0,     1,0,0};
    tbl[10] = '{0,0,1,0, P(4),  0,1,P(3),  1,1,P(3)};
    tbl[11] = '{0,1,1,0, P(5),  0,1,P(3),  0,1,P(3)};
    tbl[12] = '{0,0,0,1, P(5),  1,0,0,     1,0,0};
    tbl[13] = '{0,0,1,0, P(6),  1,0,0,     1,0,0};
    tbl[14] = '{0,0,1,0, P(7),  0,1,P(6),  1,1,P(6)};
    tbl[15] = '{1,1,1,0, P(8),  0,1,P(6),  0,1,P(6)};
    tbl[16] = '{0,0,1,0, P(9),  1,0,0,     1,0,0};
    tbl[17] = '{0,0,0,1, P(9),  1,1,P(9),  1,1,P(9)};
    tbl[18] = '{0,0,0,1, P(9),  1,0,0,     1,0,0};

    repeat (2) begin drive(1, 0, 0, 0, 32'h0); advance(); end

    // Directed sequence: first accept, stall, skid fill, flush, rst+flush mid-stall
    for (int i = 0; i < 19; i++) begin
      bit er, ev;
      logic [31:0] ep;
      drive(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].e, tbl[i].pc);
      er = SKID ? tbl[i].er2 : tbl[i].er1;
      ev = SKID ? tbl[i].ev2 : tbl[i].ev1;
      ep = SKID ? tbl[i].ep2 : tbl[i].ep1;
      chk($sformatf("table[%0d]", i), {id_ready, ex_valid, ID_EX_message},
          {er, ev, ev ? pack(ep) : {MW{1'b0}}});
      if (i == 2)
        chk("ebreak_ctrl_pc", {2'b00, ID_EX_message[184:165], ID_EX_message[63:32], 133'd0},
            {2'b00, alu_of(32'h8000_0000), 6'b000101, 32'h8000_0000, 133'd0});
      advance();
    end

    // 100 back-to-back instructions with ex_ready held high
    k = 0; ndel = 0; bub = 0; cyc = 0;
    while (ndel < 100 && cyc < 400) begin
      bit a;
      drive(0, 0, k < 100, 1, P(k < 100 ? k : 99));
      chk_model("stream");
      if (ex_valid && ex_ready) begin
        chk("stream_order", {2'b00, 153'd0, ID_EX_message[63:32]}, {2'b00, 153'd0, P(ndel)});
        ndel++;
      end
      if (k > 0 && k < 100 && !ex_valid) bub++;
      a = id_valid && model_ready();
      advance();
      if (a) k++;
      cyc++;
    end
    chk("stream_count", (MW+2)'(ndel), (MW+2)'(100));
    chk("stream_bubbles", (MW+2)'(bub), (MW+2)'(0));

    // Random traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      drive(0, $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom);
      chk_model("random");
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ysyx22041405_id_ex_stage.md
YSYX22041405_ID_EX_STAGE -- requirements
Module: ysyx22041405_id_ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-004 SHALL have port id_valid  input  1  meaning the IDU offers a decoded instruction.
REQ-005 SHALL have port id_ready  output  1  meaning the stage accepts the IDU offer this cycle.
REQ-006 SHALL have port id_imm, id_rf_rdata1, id_rf_rdata2, id_pc, id_inst  input  WIDTH each  meaning the decoded data fields.
REQ-007 SHALL have port id_rf_waddr  input  5  meaning the destination register.
REQ-008 SHALL have port id_alu_Ctrl  input  14  meaning the ALU operation one-hot.
REQ-009 SHALL have port id_flags  input  6  meaning {alu_s1_sel, alu_s2_sel, rf_we, inst_ebreak, inst_lui, inst_vaild}, MSB first.
REQ-010 SHALL have port flush  input  1  meaning discard all held and offered instructions.
REQ-011 SHALL have port ex_valid  output  1  meaning the message is valid for the EXU.
REQ-012 SHALL have port ex_ready  input  1  meaning the EXU consumes the message this cycle.
REQ-013 SHALL have port ID_EX_message  output  `ID_EX_WIDTH (185)  meaning the packed bundle.

Function
REQ-014 SHALL pack ID_EX_message as {ctrl[19:0], data[164:0]}, where ctrl = {alu_Ctrl, flags} and data = {imm, rdata1, rdata2, waddr, pc, inst}, matching `ID_CTRL_WIDTH=20 and `ID_Data_WIDTH=165.
REQ-015 SHALL accept an input only when id_valid && id_ready, and SHALL complete an output only when ex_valid && ex_ready.
REQ-016 SHALL present an instruction accepted at edge N with ex_valid=1 from edge N onward (1-cycle latency).
REQ-017 SHALL hold ID_EX_message bit-stable while ex_valid && !ex_ready.
REQ-018 SHALL drive ID_EX_message to all zeros whenever ex_valid=0, so the EXU never sees a spurious ebreak or inst_vaild.
REQ-019 SHALL deliver instructions in acceptance order, with no loss or duplication.
REQ-020 SHALL, on simultaneous accept and complete with one entry held, replace that entry with the new one; ex_valid stays 1.
REQ-021 SHALL, when flush=1 at an edge, clear all entries so that ex_valid=0 after the edge, and SHALL drop any input offered that cycle.
REQ-022 SHALL give rst priority over flush, and flush priority over accept.

Reset
REQ-023 SHALL, while rst=1 at an edge, invalidate all entries, giving ex_valid=0 and ID_EX_message=0 after the edge.
REQ-024 SHALL hold id_ready=0 during any cycle with rst=1, and SHALL make id_ready=1 in the first cycle after rst deasserts.
REQ-025 SHALL abandon any held instruction on reset mid-stall without delivering it.

Configuration
REQ-026 SHALL use the macro YSYX22041405_IDEX_SKID_EN.
REQ-027 SHALL, when the macro is defined, use main+skid entries with id_ready registered (id_ready = skid empty).
REQ-028 SHALL, in skid mode, route an input accepted while main is full and ex_ready=0 into skid, and SHALL move skid to main on the next completion.
REQ-029 SHALL, in skid mode, sustain 1 instruction/cycle when ex_ready=1.
REQ-030 SHALL, when the macro is undefined, use a single entry with id_ready = !ex_valid || ex_ready (combinational) and no skid storage.

Verification
REQ-031 SHALL cover: reset, then id_valid=1 with pc=0x80000000, inst=0x00100073, inst_ebreak=1 -> ex_valid=1 the next cycle, message[184:165] ctrl carries the ebreak bit, pc field = 0x80000000.
REQ-032 SHALL cover: ex_ready=0 for 5 cycles after a valid -> message stable every cycle; in skid mode one more accept then id_ready=0; with the macro undefined id_ready=0 immediately.
REQ-033 SHALL cover: 100 back-to-back instructions with pc=0x80000000+4k and ex_ready=1 -> all 100 delivered in order, no bubbles after the first.
REQ-034 SHALL cover: flush asserted with two entries held and id_valid=1 -> ex_valid=0 and message=0 next cycle; the flushed pcs never appear.
REQ-035 SHALL cover: rst and flush both asserted mid-stall -> ex_valid=0 and id_ready=0 that cycle; id_ready=1 the cycle after rst drops.
REQ-036 SHALL cover: random id_valid/ex_ready at 50% for 10k cycles -> a scoreboard matches every delivered message against the accepted sequence.
